bk_mem_arbiter: RTL and testbench

//  Shares the single SDRAM memory port between three requesters: video line fetch,

---
 rtl/bk_mem_arbiter.sv | 81 ++++++++
 tb/tb_bk_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_mem_arbiter.sv
// bk_mem_arbiter: fixed-priority SDRAM port arbiter (video > DMA > CPU) with a CPU anti-starvation override
module bk_mem_arbiter #(
  parameter int AW = 25,
  parameter int DW = 16,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_we,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  localparam int CW = $clog2(CPU_MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve;
  logic [1:0] win;
  logic take, finish;
  always_comb begin
    win = (cpu_req && starve == CW'(CPU_MAX_WAIT)) ? 2'd3 : vid_req ? 2'd1 : dma_req ? 2'd2 : cpu_req ? 2'd3 : 2'd0;
    take = state == IDLE && win != 2'd0;
    finish = state == BUSY && mem_ready;
    state_nx = take ? BUSY : finish ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= 2'd0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_be <= 2'd0;
      mem_wdata <= '0;
      rdata <= '0;
      vid_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_ack <= 1'b0;
      starve <= '0;
    end else begin
      vid_ack <= finish && grant == 2'd1;
      dma_ack <= finish && grant == 2'd2;
      cpu_ack <= finish && grant == 2'd3;
      // counts cycles the CPU waits while someone else owns (or nobody yet owns) the port
      starve <= (!cpu_req || (take && win == 2'd3)) ? '0 :
                (grant != 2'd3 && starve != CW'(CPU_MAX_WAIT)) ? starve + 1'b1 : starve;
      if (take) begin
        grant <= win;
        mem_req <= 1'b1;
        mem_addr <= win == 2'd1 ? vid_addr : win == 2'd2 ? dma_addr : cpu_addr;
        mem_we <= win == 2'd2 ? dma_we : (win == 2'd3 && cpu_we);
        mem_be <= win == 2'd3 ? cpu_be : 2'b11;
        mem_wdata <= win == 2'd2 ? dma_wdata : win == 2'd3 ? cpu_wdata : '0;
      end
      if (finish) begin
        mem_req <= 1'b0;
        rdata <= mem_rdata;
      end
      if (state == DONE) grant <= 2'd0;
    end
  end
endmodule

// File: tb/tb_bk_mem_arbiter.sv
// tb_bk_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level reference model
module tb_bk_mem_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int MAXW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vid_req = 0, dma_req = 0, cpu_req = 0;
  logic [AW-1:0] vid_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic dma_we = 0, cpu_we = 0;
  logic [1:0] cpu_be = 2'b11;
  logic [DW-1:0] dma_wdata = '0, cpu_wdata = '0, mem_rdata = '0;
  logic mem_ready = 0;
  logic vid_ack, dma_ack, cpu_ack, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [1:0] grant, mem_be;
  logic [AW-1:0] mem_addr;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bk_mem_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .rdata(rdata), .grant(grant),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // reference model: who owns the port, how far the transaction has progressed, how long the CPU has waited
  int owner = 0, phase = 0, cpu_waited = 0;
  logic [1:0] e_grant = 0;
  logic e_mem_req = 0, e_we = 0, e_vack = 0, e_dack = 0, e_cack = 0;
  logic [1:0] e_be = 0;
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wdata = 0, e_rdata = 0;

  task automatic model_step();
    int pick, prev_owner;
    pick = 0;
    prev_owner = owner;
    {e_vack, e_dack, e_cack} = 3'b000;
    if (reset) begin
      owner = 0; phase = 0; cpu_waited = 0;
      e_mem_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
    end else begin
      if (phase == 0) begin
        pick = (cpu_req && cpu_waited == MAXW) ? 3 : vid_req ? 1 : dma_req ? 2 : cpu_req ? 3 : 0;
        if (pick == 1) begin e_addr = vid_addr; e_we = 0; e_be = 2'b11; e_wdata = 0; end
        if (pick == 2) begin e_addr = dma_addr; e_we = dma_we; e_be = 2'b11; e_wdata = dma_wdata; end
        if (pick == 3) begin e_addr = cpu_addr; e_we = cpu_we; e_be = cpu_be; e_wdata = cpu_wdata; end
        if (pick != 0) begin owner = pick; phase = 1; e_mem_req = 1; end
      end else if (phase == 1) begin
        if (mem_ready) begin
          phase = 2; e_mem_req = 0; e_rdata = mem_rdata;
          e_vack = owner == 1; e_dack = owner == 2; e_cack = owner == 3;
        end
      end else begin
        owner = 0; phase = 0;
      end
      if (!cpu_req || pick == 3) cpu_waited = 0;
      else if (prev_owner != 3 && cpu_waited < MAXW) cpu_waited++;
    end
    e_grant = 2'(owner);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    total++;
    if ({grant, mem_req, mem_we, mem_be, vid_ack, dma_ack, cpu_ack} !== 9'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {grant, mem_req, mem_we, mem_be, vid_ack, dma_ack, cpu_ack});
    end
    total++;
    if ({mem_addr, mem_wdata, rdata} !== '0) begin
      bad++; $display("FAIL reset_data: addr=%0h wdata=%0h rdata=%0h want 0", mem_addr, mem_wdata, rdata);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_addr = 25'h1234; cpu_we = 0; cpu_be = 2'b11;
    tick();
    total++;
    if ({grant, mem_req, mem_we, mem_be} !== {2'd3, 1'b1, 1'b0, 2'b11} || mem_addr !== 25'h1234) begin
      bad++; $display("FAIL cpu_read_issue: grant=%0d req=%b we=%b be=%b addr=%0h want 3 1 0 11 1234", grant, mem_req, mem_we, mem_be, mem_addr);
    end
    tick();
    total++;
    if (mem_req !== 1 || cpu_ack !== 0) begin
      bad++; $display("FAIL cpu_read_busy: req=%b ack=%b want 1 0", mem_req, cpu_ack);
    end
    mem_ready = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 0; cpu_req = 0;
    total++;
    if (cpu_ack !== 1 || rdata !== 16'hBEEF || mem_req !== 0) begin
      bad++; $display("FAIL cpu_read_ack: ack=%b rdata=%0h req=%b want 1 beef 0", cpu_ack, rdata, mem_req);
    end
    tick();
    total++;
    if (cpu_ack !== 0 || grant !== 0) begin
      bad++; $display("FAIL cpu_read_end: ack=%b grant=%0d want 0 0", cpu_ack, grant);
    end
    tick();
  endtask

  task automatic test_priority();
    int ord[3];
    int n;
    n = 0;
    vid_req = 1; dma_req = 1; cpu_req = 1;
    vid_addr = 25'($urandom); dma_addr = 25'($urandom); cpu_addr = 25'($urandom);
    dma_we = 0; cpu_we = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      total++;
      if (int'(vid_ack) + int'(dma_ack) + int'(cpu_ack) > 1) begin
        bad++; $display("FAIL prio_overlap: acks=%b want at most one", {vid_ack, dma_ack, cpu_ack});
      end
      if (vid_ack || dma_ack || cpu_ack) begin
        ord[n] = vid_ack ? 1 : dma_ack ? 2 : 3;
        n++;
        total++;
        if (rdata !== e_rdata) begin
          bad++; $display("FAIL prio_rdata: got %0h want %0h", rdata, e_rdata);
        end
        if (vid_ack) vid_req = 0;
        if (dma_ack) dma_req = 0;
        if (cpu_ack) cpu_req = 0;
      end
      mem_ready = mem_req && !mem_ready;
      mem_rdata = 16'($urandom);
    end
    mem_ready = 0;
    total++;
    if (n != 3) begin
      bad++; $display("FAIL prio_count: got %0d acks want 3", n);
    end else begin
      total++;
      if (ord[0] != 1 || ord[1] != 2 || ord[2] != 3) begin
        bad++; $display("FAIL prio_order: got %0d %0d %0d want 1 2 3", ord[0], ord[1], ord[2]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_starvation();
    int first;
    logic got;
    first = -1; got = 0;
    vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_be = 2'b11;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      total++;
      if (grant !== e_grant || cpu_ack !== e_cack || vid_ack !== e_vack) begin
        bad++; $display("FAIL starve_cycle%0d: grant=%0d cack=%b vack=%b want %0d %b %b", i, grant, cpu_ack, vid_ack, e_grant, e_cack, e_vack);
      end
      if (grant == 2'd3 && first < 0) first = i;
      if (cpu_ack) begin got = 1; cpu_req = 0; end
      mem_ready = mem_req && !mem_ready;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL starve_timeout: cpu never acked, want ack within 40 cycles");
    end
    total++;
    if (first != 9) begin
      bad++; $display("FAIL starve_grant_cycle: got %0d want 9", first);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 5) vid_req = 0;
      tick();
      mem_ready = mem_req && !mem_ready;
    end
    mem_ready = 0;
    tick();
  endtask

  task automatic test_byte_write();
    logic [AW-1:0] a;
    a = 25'($urandom);
    cpu_req = 1; cpu_addr = a; cpu_we = 1; cpu_be = 2'b10; cpu_wdata = 16'hAA55;
    tick();
    cpu_req = 0; cpu_wdata = 16'h0; cpu_be = 2'b01; cpu_addr = 0;
    total++;
    if ({grant, mem_we, mem_be, mem_wdata} !== {2'd3, 1'b1, 2'b10, 16'hAA55}) begin
      bad++; $display("FAIL bw_issue: grant=%0d we=%b be=%b wdata=%0h want 3 1 10 aa55", grant, mem_we, mem_be, mem_wdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr, cpu_ack} !== {1'b1, 1'b1, 2'b10, 16'hAA55, a, 1'b0}) begin
        bad++; $display("FAIL bw_stable%0d: req=%b we=%b be=%b wdata=%0h addr=%0h ack=%b want 1 1 10 aa55 %0h 0", i, mem_req, mem_we, mem_be, mem_wdata, mem_addr, cpu_ack, a);
      end
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    total++;
    if (cpu_ack !== 1) begin
      bad++; $display("FAIL bw_ack: got %b want 1", cpu_ack);
    end
    tick(); tick();
  endtask

  task automatic test_reset_busy();
    logic got;
    got = 0;
    dma_req = 1; dma_addr = 25'($urandom); dma_we = 0;
    tick(); tick();
    reset = 1; dma_req = 0;
    tick();
    total++;
    if ({mem_req, grant, vid_ack, dma_ack, cpu_ack} !== 6'd0) begin
      bad++; $display("FAIL rb_abort: req=%b grant=%0d acks=%b want 0 0 000", mem_req, grant, {vid_ack, dma_ack, cpu_ack});
    end
    reset = 0;
    tick();
    total++;
    if ({vid_ack, dma_ack, cpu_ack} !== 3'd0) begin
      bad++; $display("FAIL rb_noack: acks=%b want 000", {vid_ack, dma_ack, cpu_ack});
    end
    vid_req = 1; vid_addr = 25'($urandom);
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (vid_ack) begin
        got = 1; vid_req = 0;
        total++;
        if (rdata !== e_rdata || dma_ack !== 0) begin
          bad++; $display("FAIL rb_new_data: rdata=%0h dack=%b want %0h 0", rdata, dma_ack, e_rdata);
        end
      end
      mem_ready = mem_req && !mem_ready;
      mem_rdata = 16'($urandom);
    end
    mem_ready = 0;
    total++;
    if (!got) begin
      bad++; $display("FAIL rb_new_timeout: no vid_ack within 10 cycles");
    end
    tick(); tick();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1; mem_rdata = 16'h1357;
    tick();
    mem_ready = 0;
    total++;
    if ({vid_ack, dma_ack, cpu_ack, mem_req, grant} !== 6'd0) begin
      bad++; $display("FAIL stray_ack: acks=%b req=%b grant=%0d want 000 0 0", {vid_ack, dma_ack, cpu_ack}, mem_req, grant);
    end
    tick();
    total++;
    if ({vid_ack, dma_ack, cpu_ack, mem_req, grant} !== 6'd0) begin
      bad++; $display("FAIL stray_idle: acks=%b req=%b grant=%0d want 000 0 0", {vid_ack, dma_ack, cpu_ack}, mem_req, grant);
    end
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 25'h55;
    tick();
    cpu_req = 0;
    total++;
    if (grant !== 3 || mem_req !== 1) begin
      bad++; $display("FAIL stray_next: grant=%0d req=%b want 3 1", grant, mem_req);
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    total++;
    if (cpu_ack !== 1) begin
      bad++; $display("FAIL stray_next_ack: got %b want 1", cpu_ack);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    int dly;
    dly = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      total++;
      if (grant !== e_grant || mem_req !== e_mem_req || {vid_ack, dma_ack, cpu_ack} !== {e_vack, e_dack, e_cack}) begin
        bad++; $display("FAIL rnd_ctrl@%0d: grant=%0d req=%b acks=%b want %0d %b %b", i, grant, mem_req, {vid_ack, dma_ack, cpu_ack}, e_grant, e_mem_req, {e_vack, e_dack, e_cack});
      end
      if (e_mem_req) begin
        total++;
        if ({mem_addr, mem_we, mem_be, mem_wdata} !== {e_addr, e_we, e_be, e_wdata}) begin
          bad++; $display("FAIL rnd_fields@%0d: addr=%0h we=%b be=%b wdata=%0h want %0h %b %b %0h", i, mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wdata);
        end
      end
      if (e_vack || e_dack || e_cack) begin
        total++;
        if (rdata !== e_rdata) begin
          bad++; $display("FAIL rnd_rdata@%0d: got %0h want %0h", i, rdata, e_rdata);
        end
      end
      reset = $urandom_range(0, 199) == 0;
      if (e_vack) vid_req = 1'($urandom_range(0, 1));
      else if (!vid_req && $urandom_range(0, 3) == 0) vid_req = 1;
      if (e_vack || !vid_req) vid_addr = 25'($urandom);
      if (e_dack) dma_req = 1'($urandom_range(0, 1));
      else if (!dma_req && $urandom_range(0, 4) == 0) dma_req = 1;
      if (e_dack || !dma_req) begin dma_addr = 25'($urandom); dma_we = 1'($urandom); dma_wdata = 16'($urandom); end
      if (e_cack) cpu_req = 1'($urandom_range(0, 1));
      else if (!cpu_req && $urandom_range(0, 3) == 0) cpu_req = 1;
      if (e_cack || !cpu_req) begin cpu_addr = 25'($urandom); cpu_we = 1'($urandom); cpu_be = 2'($urandom); cpu_wdata = 16'($urandom); end
      if (mem_ready) mem_ready = 0;
      else if (mem_req) begin
        if (dly == 0) begin mem_ready = 1; mem_rdata = 16'($urandom); dly = $urandom_range(0, 3); end
        else dly--;
      end else if ($urandom_range(0, 19) == 0) begin
        mem_ready = 1; mem_rdata = 16'($urandom);
      end
    end
    reset = 0; mem_ready = 0;
    vid_req = 0; dma_req = 0; cpu_req = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_starvation();
    test_byte_write();
    test_reset_busy();
    test_stray_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
